des_result_serializer: RTL and testbench

// - Pipe-out side of the block-DES datapath: takes 64-bit result blocks from the DES engine and serves them to the host PipeOut as 16-bit words.
// - Buffers up to DEPTH blocks so the engine never stalls on host read latency.
// - Counts blocks against a programmed transfer length and pulses done (to a TriggerOut bit) when the host has drained the last word.

---
 rtl/des_pipe_pkg.sv | 21 ++
 rtl/des_result_serializer_if.sv | 14 +
 rtl/des_blk_fifo.sv | 58 +++++
 rtl/des_result_serializer.sv | 106 ++++++++++
 tb/tb_des_result_serializer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pipe_pkg.sv
// Shared types for the DES result pipe-out path: block/word widths and FSM encoding.
// Word 0 of a block sits in bits [15:0]; higher words follow in ascending order.
package des_pipe_pkg;
   localparam int PIPE_W        = 16;
   localparam int BLK_W         = 64;
   localparam int WORDS_PER_BLK = 4;
   localparam int IDX_W         = $clog2(WORDS_PER_BLK);

   typedef logic [BLK_W-1:0]  blk_t;
   typedef logic [PIPE_W-1:0] word_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   function automatic word_t word_sel(blk_t blk, logic [IDX_W-1:0] idx);
      return blk[idx*PIPE_W +: PIPE_W];
   endfunction
endpackage

// File: rtl/des_result_serializer_if.sv
// Producer block handshake and host PipeOut word port of the result serializer.
// Push = blk_valid & blk_ready; pipe_read consumes the word currently on pipe_data.
interface des_result_serializer_if;
   import des_pipe_pkg::*;

   logic  blk_valid;
   blk_t  blk_data;
   logic  blk_ready;
   logic  pipe_read;
   word_t pipe_data;

   modport master (output blk_valid, blk_data, pipe_read, input blk_ready, pipe_data);
   modport slave  (input blk_valid, blk_data, pipe_read, output blk_ready, pipe_data);
endinterface

// File: rtl/des_blk_fifo.sv
// Flop-array block FIFO with combinational head: a push is visible on head the same edge it lands.
// Push ignored when full, pop ignored when empty; clear empties it and wins over push/pop.
module des_blk_fifo
   import des_pipe_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        push,
   input  logic        pop,
   input  blk_t        din,
   output blk_t        head,
   output logic        empty,
   output logic        full,
   output logic [AW:0] count
);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   blk_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~full & ~clear;
   assign do_pop  = pop & ~empty & ~clear;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign empty = (count == '0);
   assign full  = (count == DEPTH_C);
   assign head  = mem[rd_ptr];
endmodule

// File: rtl/des_result_serializer.sv
// Buffers 64-bit DES result blocks and serves them as 16-bit PipeOut words, zero added latency.
// blk_ready drops when the FIFO is full or the programmed block count has been accepted.
module des_result_serializer
   import des_pipe_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 10
) (
   input  logic                     ti_clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     flush,
   input  logic [CNT_W-1:0]         cfg_blocks,
   des_result_serializer_if.slave   bus,
   output logic                     done,
   output logic                     busy,
   output logic                     underflow,
   output logic [$clog2(DEPTH):0]   level
);
   state_e           state;
   logic [IDX_W-1:0] word_idx;
   logic [CNT_W-1:0] cfg_reg;
   logic [CNT_W-1:0] pushed_blocks;
   logic [CNT_W-1:0] read_blocks;
   blk_t             head;
   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             rd_ok;
   logic             pop;
   logic             last_word;

   assign bus.blk_ready = (state == S_STREAM) & ~fifo_full & (pushed_blocks < cfg_reg);
   assign push          = bus.blk_valid & bus.blk_ready;
   assign rd_ok         = bus.pipe_read & ~fifo_empty;
   assign pop           = rd_ok & (word_idx == IDX_W'(WORDS_PER_BLK - 1));
   assign last_word     = (state == S_STREAM) & pop & (read_blocks == cfg_reg - CNT_W'(1));
   assign bus.pipe_data = fifo_empty ? '0 : word_sel(head, word_idx);

   des_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (ti_clk),
      .rst_n (reset_n),
      .clear (flush),
      .push  (push),
      .pop   (pop),
      .din   (bus.blk_data),
      .head  (head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (level)
   );

   always_ff @(posedge ti_clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         word_idx      <= '0;
         cfg_reg       <= '0;
         pushed_blocks <= '0;
         read_blocks   <= '0;
         done          <= 1'b0;
         busy          <= 1'b0;
         underflow     <= 1'b0;
      end else if (flush) begin
         state         <= S_IDLE;
         word_idx      <= '0;
         pushed_blocks <= '0;
         read_blocks   <= '0;
         done          <= 1'b0;
         busy          <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (rd_ok)              word_idx <= word_idx + 1'b1;
         else if (bus.pipe_read) underflow <= 1'b1;
         if (push && pushed_blocks != cfg_reg) pushed_blocks <= pushed_blocks + 1'b1;
         if (pop && read_blocks != cfg_reg)    read_blocks   <= read_blocks + 1'b1;

         case (state)
            S_IDLE: begin
               if (start) begin
                  // a zero-length transfer completes immediately without streaming
                  underflow     <= 1'b0;
                  pushed_blocks <= '0;
                  read_blocks   <= '0;
                  cfg_reg       <= cfg_blocks;
                  if (cfg_blocks == '0) begin
                     done <= 1'b1;
                  end else begin
                     state <= S_STREAM;
                     busy  <= 1'b1;
                  end
               end
            end
            S_STREAM: begin
               if (last_word) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_des_result_serializer.sv
// Directed bench for des_result_serializer: hand-computed words, flags and levels.
`timescale 1ns/1ps
module tb_des_result_serializer;
   import des_pipe_pkg::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = 10;
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int NBLK  = DEPTH + 2;

   logic             ti_clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic             flush = 1'b0;
   logic [CNT_W-1:0] cfg_blocks = '0;
   logic             done;
   logic             busy;
   logic             underflow;
   logic [LVL_W-1:0] level;

   int checks = 0;
   int errors = 0;
   int pushed;
   int rd_words;
   int done_cnt;
   bit host_en;

   des_result_serializer_if bus();

   des_result_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .ti_clk     (ti_clk),
      .reset_n    (reset_n),
      .start      (start),
      .flush      (flush),
      .cfg_blocks (cfg_blocks),
      .bus        (bus),
      .done       (done),
      .busy       (busy),
      .underflow  (underflow),
      .level      (level)
   );

   always #5 ti_clk = ~ti_clk;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mkblk(int k);
      return {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)};
   endfunction

   task automatic cyc();
      @(posedge ti_clk);
      #1;
   endtask

   task automatic do_start(int n);
      start = 1'b1;
      cfg_blocks = CNT_W'(n);
      cyc();
      start = 1'b0;
   endtask

   task automatic push_blk(logic [63:0] d);
      bus.blk_valid = 1'b1;
      bus.blk_data  = d;
      cyc();
      bus.blk_valid = 1'b0;
   endtask

   task automatic read_n(int n);
      bus.pipe_read = 1'b1;
      repeat (n) cyc();
      bus.pipe_read = 1'b0;
   endtask

   // one cycle of the streaming producer/host model used by the long transfer
   task automatic step();
      bit acc;
      bit rd;
      bus.blk_valid = (pushed < NBLK);
      bus.blk_data  = mkblk(pushed);
      bus.pipe_read = host_en && (level != 0);
      #1;
      if (bus.pipe_read) check("stream_word", bus.pipe_data, 64'(rd_words));
      acc = bus.blk_valid && bus.blk_ready;
      rd  = bus.pipe_read;
      cyc();
      if (acc) pushed++;
      if (rd) rd_words++;
      if (done) done_cnt++;
   endtask

   initial begin
      word_t exp_a [4];
      exp_a = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
      bus.blk_valid = 1'b0;
      bus.blk_data  = '0;
      bus.pipe_read = 1'b0;

      #12;
      check("rst_ready", bus.blk_ready, 0);
      check("rst_data", bus.pipe_data, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_uflow", underflow, 0);
      check("rst_level", level, 0);
      cyc();
      reset_n = 1'b1;
      cyc();

      // single block, words emerge low half first
      do_start(1);
      check("a_busy", busy, 1);
      check("a_ready", bus.blk_ready, 1);
      push_blk(64'h0123_4567_89AB_CDEF);
      check("a_level", level, 1);
      check("a_ready_sat", bus.blk_ready, 0);
      bus.pipe_read = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("a_word", bus.pipe_data, 64'(exp_a[i]));
         cyc();
      end
      bus.pipe_read = 1'b0;
      check("a_done", done, 1);
      check("a_busy_end", busy, 0);
      check("a_level_end", level, 0);
      cyc();
      check("a_done_clr", done, 0);

      // DEPTH+2 blocks: fill, backpressure, drain
      pushed = 0; rd_words = 0; done_cnt = 0; host_en = 1'b0;
      do_start(NBLK);
      repeat (DEPTH + 2) step();
      check("b_pushed", 64'(pushed), DEPTH);
      check("b_level_full", level, DEPTH);
      check("b_ready_full", bus.blk_ready, 0);
      host_en = 1'b1;
      repeat (4) step();
      check("b_level_after_pop", level, DEPTH - 1);
      check("b_ready_back", bus.blk_ready, 1);
      for (int i = 0; i < 300 && rd_words < 4*NBLK; i++) step();
      bus.blk_valid = 1'b0;
      bus.pipe_read = 1'b0;
      check("b_words", 64'(rd_words), 4*NBLK);
      check("b_done_cnt", 64'(done_cnt), 1);
      check("b_uflow", underflow, 0);
      cyc();
      check("b_busy_end", busy, 0);
      check("b_done_clr", done, 0);

      // empty read while streaming
      do_start(1);
      read_n(1);
      check("c_uflow", underflow, 1);
      check("c_data", bus.pipe_data, 0);
      push_blk(mkblk(50));
      check("c_idx_kept", bus.pipe_data, 200);
      read_n(4);
      check("c_done", done, 1);
      check("c_uflow_sticky", underflow, 1);
      cyc();
      do_start(0);
      check("c_uflow_clr", underflow, 0);
      check("c_zero_done", done, 1);
      check("c_zero_busy", busy, 0);
      cyc();
      check("c_zero_done_clr", done, 0);

      // flush mid transfer
      do_start(3);
      push_blk(mkblk(100));
      push_blk(mkblk(101));
      read_n(5);
      check("d_pre_word", bus.pipe_data, 405);
      check("d_pre_level", level, 1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      check("d_busy", busy, 0);
      check("d_level", level, 0);
      check("d_ready", bus.blk_ready, 0);
      check("d_done", done, 0);
      check("d_data", bus.pipe_data, 0);
      cyc();
      check("d_done_later", done, 0);
      do_start(1);
      push_blk(mkblk(110));
      check("d_idx_reset", bus.pipe_data, 440);
      read_n(4);
      check("d_restart_done", done, 1);
      cyc();

      // flush beats start
      start = 1'b1; flush = 1'b1; cfg_blocks = CNT_W'(1);
      cyc();
      start = 1'b0; flush = 1'b0;
      check("f_busy", busy, 0);
      check("f_ready", bus.blk_ready, 0);

      // push coinciding with pop of the last word at level 1
      do_start(2);
      push_blk(mkblk(200));
      read_n(3);
      check("e_word3", bus.pipe_data, 803);
      check("e_ready", bus.blk_ready, 1);
      bus.blk_valid = 1'b1;
      bus.blk_data  = mkblk(201);
      bus.pipe_read = 1'b1;
      cyc();
      bus.blk_valid = 1'b0;
      bus.pipe_read = 1'b0;
      check("e_level", level, 1);
      check("e_new_word", bus.pipe_data, 804);
      check("e_no_done", done, 0);
      read_n(4);
      check("e_done", done, 1);
      cyc();

      // asynchronous reset in the middle of a transfer
      do_start(2);
      push_blk(mkblk(300));
      read_n(1);
      check("g_pre_busy", busy, 1);
      #3;
      reset_n = 1'b0;
      #1;
      check("g_busy", busy, 0);
      check("g_level", level, 0);
      check("g_data", bus.pipe_data, 0);
      check("g_ready", bus.blk_ready, 0);
      check("g_done", done, 0);
      cyc();
      reset_n = 1'b1;
      cyc();
      do_start(0);
      check("g_zero_done", done, 1);
      check("g_zero_busy", busy, 0);
      cyc();
      check("g_zero_done_clr", done, 0);
      check("g_busy_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
